// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: op codes, FSM states
// and small op-classification helpers.
package mem_pkg;

  localparam int MEM_OP_W = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LBU  = 4'd2,
    LH   = 4'd3,
    LHU  = 4'd4,
    LW   = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    DRAIN
  } state_e;

  function automatic logic is_load(
    input logic [MEM_OP_W-1:0] op
  );
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic is_store(
    input logic [MEM_OP_W-1:0] op
  );
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_misaligned(
    input logic [MEM_OP_W-1:0] op,
    input logic [1:0]          lo
  );
    return ((op == LH || op == LHU) && lo[0])
        || ((op == LW || op == SW) && lo != 2'b00)
        || (op == SH && lo[0]);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/gnt request phase,
// rvalid response phase.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dm_req_o;
  logic              dm_we_o;
  logic [ADDR_W-1:0] dm_addr_o;
  logic [3:0]        dm_be_o;
  logic [DATA_W-1:0] dm_wdata_o;
  logic              dm_gnt_i;
  logic              dm_rvalid_i;
  logic [DATA_W-1:0] dm_rdata_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o,
    output dm_be_o, dm_wdata_o,
    input  dm_gnt_i, dm_rvalid_i, dm_rdata_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o,
    input  dm_be_o, dm_wdata_o,
    output dm_gnt_i, dm_rvalid_i, dm_rdata_i
  );
endinterface

// File: rtl/mem_access_stage_lane.sv
// Byte-lane steering for stores and load data
// extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [MEM_OP_W-1:0] st_op_i,
  input  logic [1:0]          st_off_i,
  input  logic [31:0]         st_data_i,
  output logic [3:0]          be_o,
  output logic [31:0]         wdata_o,
  input  logic [MEM_OP_W-1:0] ld_op_i,
  input  logic [1:0]          ld_off_i,
  input  logic [31:0]         rdata_i,
  output logic [31:0]         ld_data_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_h = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  // store byte enables and lane replication
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    unique case (1'b1)
      (st_op_i == SB): begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      (st_op_i == SH): begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      (st_op_i == SW): be_o = 4'b1111;
      is_load(st_op_i): be_o = 4'b1111;
      default: ;
    endcase
  end

  // load extraction and extension
  always_comb begin
    ld_data_o = rdata_i;
    unique case (1'b1)
      (ld_op_i == LB):  ld_data_o = {{24{ld_b[7]}}, ld_b};
      (ld_op_i == LBU): ld_data_o = {24'b0, ld_b};
      (ld_op_i == LH):  ld_data_o = {{16{ld_h[15]}}, ld_h};
      (ld_op_i == LHU): ld_data_o = {16'b0, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory FSM, stall/flush handling
// and the registered MEM/WB output.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  input  logic [MEM_OP_W-1:0] mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                write_reg_en_i,
  input  logic [REG_AW-1:0]   write_reg_addr_i,
  input  logic [DATA_W-1:0]   write_reg_data_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  mem_access_stage_if.master  dm,
  output logic                wb_valid_o,
  output logic                write_reg_en_o,
  output logic [REG_AW-1:0]   write_reg_addr_o,
  output logic [DATA_W-1:0]   write_reg_data_o,
  output logic                exc_misalign_o
);

  if (DATA_W != 32) begin : g_dw_chk
    $error("mem_access_stage: DATA_W must be 32");
  end

  state_e              state_q, state_d;
  logic [MEM_OP_W-1:0] ld_op_q, ld_op_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                exc_q, exc_d;

  logic                is_mem, mis, go;
  logic                req, stall, complete, wb_load;
  logic [3:0]          be_w;
  logic [DATA_W-1:0]   wdata_w, ld_data;

  assign is_mem = is_load(mem_op_i)
                | is_store(mem_op_i);
  assign mis    = is_misaligned(mem_op_i,
                                mem_addr_i[1:0]);
  assign go     = ex_valid_i & is_mem
                & ~mis & ~flush_i;

  mem_lane_align u_lane (
    .st_op_i   (mem_op_i),
    .st_off_i  (mem_addr_i[1:0]),
    .st_data_i (mem_wdata_i),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .ld_op_i   (ld_op_q),
    .ld_off_i  (ld_off_q),
    .rdata_i   (dm.dm_rdata_i),
    .ld_data_o (ld_data)
  );

  // bus FSM: request, wait for response, drain
  always_comb begin
    state_d  = state_q;
    ld_op_d  = ld_op_q;
    ld_off_d = ld_off_q;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = go;
        if (go && dm.dm_gnt_i) begin
          if (is_store(mem_op_i)) begin
            complete = 1'b1;
          end else begin
            state_d  = WAIT_RSP;
            ld_op_d  = mem_op_i;
            ld_off_d = mem_addr_i[1:0];
          end
        end
        stall = go & ~complete;
      end
      WAIT_RSP: begin
        if (dm.dm_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
        stall = go & ~complete;
      end
      DRAIN: begin
        if (dm.dm_rvalid_i) state_d = IDLE;
        stall = ex_valid_i & is_mem;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_load = ex_valid_i & ~stall & ~flush_i;

  // next MEM/WB contents
  always_comb begin
    wb_valid_d = wb_load;
    wr_en_d    = wb_load & write_reg_en_i & ~mis;
    exc_d      = wb_load & mis;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (wb_load) begin
      wr_addr_d = write_reg_addr_i;
      wr_data_d = is_load(mem_op_i) ? ld_data
                                    : write_reg_data_i;
    end
  end

  // state and MEM/WB registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ld_op_q    <= '0;
      ld_off_q   <= '0;
      wb_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_op_q    <= ld_op_d;
      ld_off_q   <= ld_off_d;
      wb_valid_q <= wb_valid_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      exc_q      <= exc_d;
    end
  end

  assign stall_req_o   = rst & stall;
  assign dm.dm_req_o   = rst & req;
  assign dm.dm_we_o    = rst & is_store(mem_op_i);
  assign dm.dm_addr_o  = rst ? {mem_addr_i[ADDR_W-1:2], 2'b00}
                             : '0;
  assign dm.dm_be_o    = rst ? be_w : 4'b0000;
  assign dm.dm_wdata_o = rst ? wdata_w : '0;

  assign wb_valid_o       = wb_valid_q;
  assign write_reg_en_o   = wr_en_q;
  assign write_reg_addr_o = wr_addr_q;
  assign write_reg_data_o = wr_data_q;
  assign exc_misalign_o   = exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a
// byte-addressed reference memory model.
module tb_mem_access_stage;
  import mem_pkg::*;

  typedef struct {
    logic        en;
    logic [4:0]  ra;
    logic [31:0] d;
    logic        exc;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        write_reg_en_i = 1'b0;
  logic [4:0]  write_reg_addr_i = '0;
  logic [31:0] write_reg_data_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_req_o;
  logic        wb_valid_o;
  logic        write_reg_en_o;
  logic [4:0]  write_reg_addr_o;
  logic [31:0] write_reg_data_o;
  logic        exc_misalign_o;

  mem_access_stage_if dm ();

  mem_access_stage dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .mem_op_i         (mem_op_i),
    .mem_addr_i       (mem_addr_i),
    .mem_wdata_i      (mem_wdata_i),
    .write_reg_en_i   (write_reg_en_i),
    .write_reg_addr_i (write_reg_addr_i),
    .write_reg_data_i (write_reg_data_i),
    .flush_i          (flush_i),
    .stall_req_o      (stall_req_o),
    .dm               (dm),
    .wb_valid_o       (wb_valid_o),
    .write_reg_en_o   (write_reg_en_o),
    .write_reg_addr_o (write_reg_addr_o),
    .write_reg_data_o (write_reg_data_o),
    .exc_misalign_o   (exc_misalign_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [7:0]  rmem [int];
  logic [31:0] bmem [int];

  int gnt_cfg = 0;
  int rv_cfg  = 0;

  int          stall_cnt;
  logic        cap_req;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, cap_addr;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h",
               n, act, exp);
    end
  endtask

  function automatic longint rb(input int a);
    return rmem.exists(a) ? longint'(rmem[a]) : 0;
  endfunction

  function automatic logic [31:0] bus_rd(input int w);
    return bmem.exists(w) ? bmem[w] : 32'h0;
  endfunction

  task automatic set_word(input int w,
                          input logic [31:0] v);
    bmem[w] = v;
    for (int i = 0; i < 4; i++)
      rmem[4*w+i] = v[8*i +: 8];
  endtask

  // reference: byte memory, spec rules in plain arithmetic
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic wen,
                       input logic [4:0] ra,
                       input logic [31:0] alu);
    exp_t e;
    logic m;
    longint v;
    int ai;
    ai = int'(a);
    m = ((op == LH || op == LHU) && a[0])
     || ((op == LW || op == SW) && a[1:0] != 2'b00)
     || (op == SH && a[0]);
    e.en = wen && !m;
    e.ra = ra;
    e.exc = m;
    e.d = alu;
    e.chk = 1'b1;
    if (op inside {LB, LBU, LH, LHU, LW}) begin
      if (m) e.chk = 1'b0;
      else begin
        case (op)
          LB, LBU: begin
            v = rb(ai);
            if (op == LB && v >= 128) v -= 256;
          end
          LH, LHU: begin
            v = rb(ai) + 256 * rb(ai+1);
            if (op == LH && v >= 32768) v -= 65536;
          end
          default: v = rb(ai) + 256 * rb(ai+1)
                     + 65536 * rb(ai+2)
                     + 16777216 * rb(ai+3);
        endcase
        e.d = v[31:0];
      end
    end else if (!m) begin
      case (op)
        SB: rmem[ai] = wd[7:0];
        SH: begin
          rmem[ai]   = wd[7:0];
          rmem[ai+1] = wd[15:8];
        end
        SW: for (int i = 0; i < 4; i++)
              rmem[ai+i] = wd[8*i +: 8];
        default: ;
      endcase
    end
    q.push_back(e);
  endtask

  function automatic int pick_g();
    return gnt_cfg < 0 ? int'($urandom_range(0, 3))
                       : gnt_cfg;
  endfunction

  function automatic int pick_r();
    return rv_cfg < 0 ? int'($urandom_range(0, 3))
                      : rv_cfg;
  endfunction

  // memory responder with programmable wait states
  initial begin : responder
    int wcnt, rcnt, paddr, w;
    logic pend;
    logic [31:0] t;
    dm.dm_gnt_i = 1'b0;
    dm.dm_rvalid_i = 1'b0;
    dm.dm_rdata_i = '0;
    pend = 1'b0;
    wcnt = 0;
    rcnt = 0;
    paddr = 0;
    forever begin
      @(posedge clk);
      #2;
      dm.dm_gnt_i = 1'b0;
      dm.dm_rvalid_i = 1'b0;
      if (!rst) begin
        pend = 1'b0;
        wcnt = pick_g();
      end else if (pend) begin
        if (rcnt == 0) begin
          dm.dm_rvalid_i = 1'b1;
          dm.dm_rdata_i = bus_rd(paddr);
          pend = 1'b0;
        end else rcnt--;
      end else if (dm.dm_req_o) begin
        if (wcnt == 0) begin
          dm.dm_gnt_i = 1'b1;
          w = int'(dm.dm_addr_o >> 2);
          if (dm.dm_we_o) begin
            t = bus_rd(w);
            for (int i = 0; i < 4; i++)
              if (dm.dm_be_o[i])
                t[8*i +: 8] = dm.dm_wdata_o[8*i +: 8];
            bmem[w] = t;
          end else begin
            pend = 1'b1;
            paddr = w;
            rcnt = pick_r();
          end
          wcnt = pick_g();
        end else wcnt--;
      end else begin
        wcnt = pick_g();
      end
    end
  end

  // monitor: pop and compare on every MEM/WB output
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wb: got data %h required none",
                 write_reg_data_o);
      end else begin
        mon_e = q.pop_front();
        chk("wb_en", 32'(write_reg_en_o), 32'(mon_e.en));
        chk("wb_addr", 32'(write_reg_addr_o),
            32'(mon_e.ra));
        chk("wb_exc", 32'(exc_misalign_o),
            32'(mon_e.exc));
        if (mon_e.chk)
          chk("wb_data", write_reg_data_o, mon_e.d);
      end
    end
  end

  task automatic idle(input int n);
    ex_valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic wen,
                         input logic [4:0] ra,
                         input logic [31:0] alu);
    ex_valid_i = 1'b1;
    mem_op_i = op;
    mem_addr_i = a;
    mem_wdata_i = wd;
    write_reg_en_i = wen;
    write_reg_addr_i = ra;
    write_reg_data_i = alu;
  endtask

  // drive one instruction and hold it while stalled
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic wen,
                       input logic [4:0] ra,
                       input logic [31:0] alu);
    logic acc;
    model(op, a, wd, wen, ra, alu);
    present(op, a, wd, wen, ra, alu);
    stall_cnt = 0;
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cap_req = dm.dm_req_o;
        cap_be = dm.dm_be_o;
        cap_wdata = dm.dm_wdata_o;
        cap_addr = dm.dm_addr_o;
      end
      if (stall_req_o) stall_cnt++;
      else acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
    ex_valid_i = 1'b0;
  endtask

  initial begin : main
    logic acc, drained, early, nostall;
    for (int w = 0; w < 16; w++) set_word(w, $urandom);
    set_word(32'h100 >> 2, 32'h80FF_0000);
    set_word(32'h40 >> 2, 32'hDEAD_BEEF);
    set_word(32'h44 >> 2, 32'h1357_9BDF);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    present(LW, 32'h0, 32'h0, 1'b1, 5'd1, 32'h0);
    #1;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wr_data", write_reg_data_o, 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_req", 32'(dm.dm_req_o), 32'd0);
    ex_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU pass-through
    issue(NONE, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234_5678);
    chk("alu_stall", 32'(stall_cnt), 32'd0);
    chk("alu_valid", 32'(wb_valid_o), 32'd1);
    chk("alu_data", write_reg_data_o, 32'h1234_5678);
    chk("alu_addr", 32'(write_reg_addr_o), 32'd3);

    // LB / LBU with wait states
    gnt_cfg = 2;
    rv_cfg = 2;
    idle(2);
    issue(LB, 32'h103, 32'h0, 1'b1, 5'd5, 32'h0);
    chk("lb_stall", 32'(stall_cnt), 32'd5);
    chk("lb_data", write_reg_data_o, 32'hFFFF_FF80);
    idle(2);
    issue(LBU, 32'h103, 32'h0, 1'b1, 5'd5, 32'h0);
    chk("lbu_stall", 32'(stall_cnt), 32'd5);
    chk("lbu_data", write_reg_data_o, 32'h0000_0080);

    // SH lane steering, same-cycle grant
    gnt_cfg = 0;
    rv_cfg = 0;
    idle(2);
    issue(SH, 32'h202, 32'h0000_ABCD, 1'b0, 5'd4,
          32'h11);
    chk("sh_req", 32'(cap_req), 32'd1);
    chk("sh_be", 32'(cap_be), 32'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_stall", 32'(stall_cnt), 32'd0);
    chk("sh_wren", 32'(write_reg_en_o), 32'd0);

    // misaligned LW
    issue(LW, 32'h301, 32'h0, 1'b1, 5'd6, 32'h0);
    chk("mis_req", 32'(cap_req), 32'd0);
    chk("mis_stall", 32'(stall_cnt), 32'd0);
    chk("mis_exc", 32'(exc_misalign_o), 32'd1);
    chk("mis_wren", 32'(write_reg_en_o), 32'd0);
    chk("mis_valid", 32'(wb_valid_o), 32'd1);

    // flush while waiting for the response
    rv_cfg = 3;
    idle(2);
    present(LW, 32'h40, 32'h0, 1'b1, 5'd7, 32'h0);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    model(LW, 32'h44, 32'h0, 1'b1, 5'd8, 32'h0);
    present(LW, 32'h44, 32'h0, 1'b1, 5'd8, 32'h0);
    acc = 1'b0;
    drained = 1'b0;
    early = 1'b0;
    nostall = 1'b0;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      if (!drained) begin
        if (dm.dm_req_o) early = 1'b1;
        if (!stall_req_o) nostall = 1'b1;
        if (dm.dm_rvalid_i) drained = 1'b1;
      end else if (!stall_req_o) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    ex_valid_i = 1'b0;
    chk("drain_seen", 32'(drained), 32'd1);
    chk("drain_no_req", 32'(early), 32'd0);
    chk("drain_stall", 32'(nostall), 32'd0);
    chk("drain_done", 32'(acc), 32'd1);
    chk("drain_data", write_reg_data_o, 32'h1357_9BDF);

    // asynchronous reset in WAIT_RSP
    rv_cfg = 6;
    idle(2);
    issue(NONE, 32'h0, 32'h0, 1'b1, 5'd9, 32'hCAFE_0001);
    present(LW, 32'h8, 32'h0, 1'b1, 5'd10, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_rst_stall", 32'(stall_req_o), 32'd1);
    chk("pre_rst_data", write_reg_data_o, 32'hCAFE_0001);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_req_o), 32'd0);
    chk("arst_data", write_reg_data_o, 32'd0);
    chk("arst_addr", 32'(write_reg_addr_o), 32'd0);
    chk("arst_req", 32'(dm.dm_req_o), 32'd0);
    ex_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_stall", 32'(stall_req_o), 32'd0);
    rv_cfg = 0;
    issue(LW, 32'h8, 32'h0, 1'b1, 5'd11, 32'h0);
    chk("post_rst_req", 32'(cap_req), 32'd1);

    // randomized stream
    gnt_cfg = -1;
    rv_cfg = -1;
    idle(2);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0)
        idle(int'($urandom_range(1, 2)));
      issue(4'($urandom_range(0, 8)),
            32'($urandom_range(0, 63)),
            $urandom,
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)),
            $urandom);
    end
    idle(1);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
